pc_fetch_unit: RTL and testbench

//  Holds the program counter and fetches instructions for the decode stage.

---
 rtl/pc_fetch_unit.sv | 139 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch front end.
// The PC either steps by one word or takes a redirect target. Words returned
// by instruction memory are placed in a 2-entry buffer with a registered head
// that the decoder drains through a valid/ready handshake. A fetch is issued
// only while buffer occupancy plus the outstanding request stays below two.
module pc_fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;        // next fetch address / latched redirect target
  logic [ADDR_W-1:0] hold_q, hold_d;    // address of the abandoned request while discarding

  // Buffer: slot 0 is the head and drives the inst_* outputs directly.
  logic              v0_q, v0_d, v1_q, v1_d;
  logic [ADDR_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d;

  logic              pop;
  logic              push;
  logic [1:0]        cnt_base;          // occupancy after this cycle's pop/flush, before any push

  assign pop      = v0_q & inst_ready;
  assign cnt_base = redirect_valid ? 2'd0
                  : ({1'b0, v0_q} + {1'b0, v1_q} - {1'b0, pop});

  assign imem_req   = (state_q != IDLE);
  // While discarding, the old request address must stay on the bus even
  // though pc_q already holds the new target.
  assign imem_addr  = (state_q == DISCARD) ? hold_q : pc_q;
  assign inst_valid = v0_q;
  assign inst_pc    = pc0_q;
  assign inst_data  = d0_q;

  // Next-state, PC update and push decision for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = redirect_addr;
        if (cnt_base < 2'd2) state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack && redirect_valid) begin
          // Returned word belongs to the wrong path: drop it, refetch at target.
          pc_d = redirect_addr;
        end else if (imem_ack) begin
          push = 1'b1;
          pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (cnt_base + 2'd1 >= 2'd2) state_d = IDLE;
        end else if (redirect_valid) begin
          pc_d    = redirect_addr;
          hold_d  = pc_q;
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect_valid) pc_d = redirect_addr;
        // The ack closes the abandoned request; its data is never pushed.
        if (imem_ack) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer next state: pop shifts slot 1 to the head, push fills the first free slot, redirect flushes.
  always_comb begin
    v0_d  = pop ? v1_q  : v0_q;
    pc0_d = pop ? pc1_q : pc0_q;
    d0_d  = pop ? d1_q  : d0_q;
    v1_d  = pop ? 1'b0  : v1_q;
    pc1_d = pc1_q;
    d1_d  = d1_q;
    if (redirect_valid) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else if (push) begin
      if (!v0_d) begin
        v0_d  = 1'b1;
        pc0_d = pc_q;
        d0_d  = imem_rdata;
      end else begin
        v1_d  = 1'b1;
        pc1_d = pc_q;
        d1_d  = imem_rdata;
      end
    end
  end

  // State, PC and buffer registers; reset forces every output to its idle value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      hold_q  <= RESET_PC;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      pc0_q   <= '0;
      pc1_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;

  always #5 clk = ~clk;

  pc_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of delivered words, the PC, and the in-flight request.
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_out;        // a request is on the bus
  logic [31:0] m_req_addr;   // its address
  bit          m_stale;      // it was overtaken by a redirect

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0;
    m_out = 1'b0;
    m_req_addr = 32'h0;
    m_stale = 1'b0;
  endtask

  task automatic model_step(input bit redir, input logic [31:0] raddr, input bit ack, input bit rdy);
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (m_out && ack && !m_stale && !redir) begin
      mq.push_back('{pc: m_req_addr, data: memf(m_req_addr)});
      m_pc = m_req_addr + 32'd1;
    end
    if (redir) begin
      mq.delete();
      m_pc = raddr;
    end
    if (m_out && !ack) begin
      if (redir) m_stale = 1'b1;
    end else begin
      m_out = (mq.size() < 2);
      m_req_addr = m_pc;
      m_stale = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_out});
    if (m_out) chk("imem_addr", imem_addr, m_req_addr);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst_data", inst_data, mq[0].data);
    end
  endtask

  // One clock: check outputs, drive inputs, advance the model, step to posedge+1.
  task automatic cycle(input bit redir, input logic [31:0] raddr, input bit ack, input bit rdy);
    bit a;
    check_outputs();
    a = ack && m_out;
    redirect_valid = redir;
    redirect_addr  = raddr;
    imem_ack       = a;
    imem_rdata     = m_out ? memf(m_req_addr) : 32'hDEADBEEF;
    inst_ready     = rdy;
    model_step(redir, raddr, a, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    inst_ready = 1'b0;
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int nreq;
    logic [31:0] ra;
    #2;

    // T1: ack every cycle, ready high: first valid two cycles after release, then 0,1,2,3.
    apply_reset();
    cycle(0, 0, 1, 1);
    chk("T1_no_valid_yet", {31'b0, inst_valid}, 32'h0);
    cycle(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      chk("T1_valid", {31'b0, inst_valid}, 32'h1);
      chk("T1_pc", inst_pc, i);
      cycle(0, 0, 1, 1);
    end

    // T2: decoder stalled, only two words fetched, then delivered in order.
    apply_reset();
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req === 1'b1) nreq++;
      cycle(0, 0, 1, 0);
    end
    chk("T2_acks", nreq, 2);
    chk("T2_req_idle", {31'b0, imem_req}, 32'h0);
    chk("T2_head_pc", inst_pc, 32'h0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1);

    // T3: slow ack with redirect during the wait; address held, data dropped.
    apply_reset();
    cycle(0, 0, 0, 1);
    chk("T3_addr_w0", imem_addr, 32'h0);
    cycle(1, 32'h40, 0, 1);
    chk("T3_addr_w1", imem_addr, 32'h0);
    cycle(0, 0, 0, 1);
    chk("T3_addr_w2", imem_addr, 32'h0);
    cycle(0, 0, 0, 1);
    chk("T3_addr_w3", imem_addr, 32'h0);
    cycle(0, 0, 1, 1);
    chk("T3_next_addr", imem_addr, 32'h40);
    chk("T3_no_stale", {31'b0, inst_valid}, 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1);

    // T4: redirect coincides with the ack for pc 5 while a word is buffered.
    apply_reset();
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1);
    chk("T4_head_pc", inst_pc, 32'h4);
    chk("T4_req_addr", imem_addr, 32'h5);
    cycle(1, 32'h80, 1, 0);
    chk("T4_flushed", {31'b0, inst_valid}, 32'h0);
    chk("T4_next_addr", imem_addr, 32'h80);

    // T5: PC wraps from all-ones to zero.
    cycle(1, 32'hFFFFFFFF, 1, 1);
    chk("T5_addr_top", imem_addr, 32'hFFFFFFFF);
    cycle(0, 0, 1, 1);
    chk("T5_pc_top", inst_pc, 32'hFFFFFFFF);
    chk("T5_addr_wrap", imem_addr, 32'h0);
    cycle(0, 0, 1, 1);
    chk("T5_pc_wrap", inst_pc, 32'h0);
    cycle(0, 0, 1, 1);

    // T6: reset while a request is pending and the buffer holds data.
    apply_reset();
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    chk("T6_pre_req", {31'b0, imem_req}, 32'h1);
    chk("T6_pre_valid", {31'b0, inst_valid}, 32'h1);
    apply_reset();
    cycle(0, 0, 0, 1);
    chk("T6_first_fetch", imem_addr, 32'h0);
    chk("T6_first_req", {31'b0, imem_req}, 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        ra = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - $urandom_range(0, 2)) : $urandom;
        cycle($urandom_range(0, 9) == 0, ra, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      end
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
